// File: rtl/spi_cmd_controller.sv
// SPI command sequencer: parses opcode/address/data frames delimited by slave
// select and issues single-cycle register write strobes, with burst auto-increment.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no frame in progress, waiting for the opcode byte while selected
// ADDR    | WRITE_SINGLE/WRITE_BURST opcode seen, waiting for address byte
// DATA    | writing data bytes; burst stays here and increments the address
// DONE    | frame complete (NOP or single write), any further byte is an error
// DISCARD | frame already malformed, remaining bytes ignored
module spi_cmd_controller #(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_ss,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              reg_wr_en,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              cmd_error,
  output logic [7:0]        frame_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_DONE,
    S_DISCARD
  } state_t;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_SINGLE = 8'h01;
  localparam logic [7:0] OP_BURST  = 8'h02;

  logic              ss_meta_q, ss_s_q;
  state_t            state_q, state_d;
  logic              err_q, err_d;
  logic              wrote_q, wrote_d;
  logic              burst_q, burst_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [7:0]        count_q, count_d;

  // Post-byte values, used both as next state and for frame classification
  state_t            st_b;
  logic              err_b, wrote_b;
  logic              frame_end, good;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_meta_q <= 1'b1;
      ss_s_q    <= 1'b1;
    end else begin
      ss_meta_q <= spi_ss;
      ss_s_q    <= ss_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      err_q     <= 1'b0;
      wrote_q   <= 1'b0;
      burst_q   <= 1'b0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'h00;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      count_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      wrote_q   <= wrote_d;
      burst_q   <= burst_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      error_q   <= error_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    st_b      = state_q;
    err_b     = err_q;
    wrote_b   = wrote_q;
    burst_d   = burst_q;
    addr_d    = addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    count_d   = count_q;
    good      = 1'b0;
    frame_end = ss_s_q && (state_q != S_IDLE);

    if (byte_valid) begin
      case (state_q)
        S_IDLE: begin
          if (!ss_s_q) begin
            case (byte_in)
              OP_NOP: st_b = S_DONE;
              OP_SINGLE: begin
                burst_d = 1'b0;
                st_b    = S_ADDR;
              end
              OP_BURST: begin
                burst_d = 1'b1;
                st_b    = S_ADDR;
              end
              default: begin
                err_b = 1'b1;
                st_b  = S_DISCARD;
              end
            endcase
          end
        end
        S_ADDR: begin
          addr_d  = byte_in[ADDR_W-1:0];
          wrote_b = 1'b0;
          st_b    = S_DATA;
        end
        S_DATA: begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = byte_in;
          wrote_b   = 1'b1;
          if (burst_q) addr_d = addr_q + 1'b1;
          else         st_b   = S_DONE;
        end
        S_DONE: begin
          err_b = 1'b1;
          st_b  = S_DISCARD;
        end
        default: ;
      endcase
    end

    state_d = st_b;
    err_d   = err_b;
    wrote_d = wrote_b;

    // A byte coinciding with deselect is folded in before classification
    if (frame_end) begin
      good    = !err_b && ((st_b == S_DONE) || ((st_b == S_DATA) && wrote_b));
      done_d  = good;
      error_d = !good;
      if (good) count_d = count_q + 8'd1;
      state_d = S_IDLE;
      err_d   = 1'b0;
      wrote_d = 1'b0;
    end
  end

  assign reg_wr_en   = wr_en_q;
  assign reg_addr    = wr_addr_q;
  assign reg_wr_data = wr_data_q;
  assign busy        = (state_q != S_IDLE);
  assign frame_done  = done_q;
  assign cmd_error   = error_q;
  assign frame_count = count_q;

endmodule

// File: tb/tb_spi_cmd_controller.sv
// Directed bench for spi_cmd_controller: frame parsing, burst wrap, error
// classification, deselect/byte coincidence and mid-frame reset.
module tb_spi_cmd_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_ss = 1'b1;
  logic [7:0] byte_in = 8'h00;
  logic       byte_valid = 1'b0;
  logic       reg_wr_en;
  logic [6:0] reg_addr;
  logic [7:0] reg_wr_data;
  logic       busy, frame_done, cmd_error;
  logic [7:0] frame_count;

  int n_cmp = 0;
  int n_bad = 0;

  // write / pulse log filled by the monitor
  logic [6:0] wa [64];
  logic [7:0] wd [64];
  int nw = 0, nd = 0, ne = 0;
  int bw, bd, be;

  always #5 clk = ~clk;

  spi_cmd_controller #(.ADDR_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .spi_ss(spi_ss), .byte_in(byte_in),
    .byte_valid(byte_valid), .reg_wr_en(reg_wr_en), .reg_addr(reg_addr),
    .reg_wr_data(reg_wr_data), .busy(busy), .frame_done(frame_done),
    .cmd_error(cmd_error), .frame_count(frame_count)
  );

  always @(negedge clk) begin
    if (reg_wr_en && nw < 64) begin
      wa[nw] = reg_addr;
      wd[nw] = reg_wr_data;
      nw = nw + 1;
    end
    if (frame_done) nd = nd + 1;
    if (cmd_error)  ne = ne + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mark();
    #1;
    bw = nw; bd = nd; be = ne;
  endtask

  task automatic ss_low();
    @(negedge clk);
    spi_ss = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic ss_high();
    @(negedge clk);
    spi_ss = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    byte_in    = b;
    byte_valid = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_wr_en", reg_wr_en, 0);
    check("rst_addr", reg_addr, 0);
    check("rst_data", reg_wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_flags", {frame_done, cmd_error}, 0);
    check("rst_count", frame_count, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // byte while deselected is ignored
    mark();
    send(8'h01);
    @(negedge clk);
    check("idle_ss_high_busy", busy, 0);

    // single write
    ss_low();
    mark();
    send(8'h01);
    check("single_busy", busy, 1);
    send(8'h05);
    send(8'hA5);
    ss_high();
    check("single_nwr", nw - bw, 1);
    check("single_addr", wa[bw], 7'h05);
    check("single_data", wd[bw], 8'hA5);
    check("single_done", nd - bd, 1);
    check("single_err", ne - be, 0);
    check("single_count", frame_count, 1);
    check("single_busy_end", busy, 0);

    // burst with address wrap, back-to-back bytes
    ss_low();
    mark();
    @(negedge clk);
    byte_valid = 1'b1;
    foreach (wd[i]) if (i < 5) begin
      case (i)
        0: byte_in = 8'h02;
        1: byte_in = 8'h7E;
        2: byte_in = 8'h11;
        3: byte_in = 8'h22;
        default: byte_in = 8'h33;
      endcase
      @(negedge clk);
    end
    byte_valid = 1'b0;
    ss_high();
    check("burst_nwr", nw - bw, 3);
    check("burst_w0", {wa[bw], wd[bw]}, {7'h7E, 8'h11});
    check("burst_w1", {wa[bw+1], wd[bw+1]}, {7'h7F, 8'h22});
    check("burst_w2", {wa[bw+2], wd[bw+2]}, {7'h00, 8'h33});
    check("burst_done", nd - bd, 1);
    check("burst_count", frame_count, 2);

    // illegal opcode
    ss_low();
    mark();
    send(8'h55); send(8'h01); send(8'h02); send(8'h03);
    ss_high();
    check("illegal_nwr", nw - bw, 0);
    check("illegal_err", ne - be, 1);
    check("illegal_done", nd - bd, 0);
    check("illegal_count", frame_count, 2);

    // single with trailing extra byte
    ss_low();
    mark();
    send(8'h01); send(8'h10); send(8'h01); send(8'h02);
    ss_high();
    check("extra_nwr", nw - bw, 1);
    check("extra_w0", {wa[bw], wd[bw]}, {7'h10, 8'h01});
    check("extra_err", ne - be, 1);
    check("extra_done", nd - bd, 0);
    check("extra_count", frame_count, 2);

    // truncated burst (no data)
    ss_low();
    mark();
    send(8'h02); send(8'h20);
    ss_high();
    check("trunc_nwr", nw - bw, 0);
    check("trunc_err", ne - be, 1);
    check("trunc_done", nd - bd, 0);

    // NOP
    ss_low();
    mark();
    send(8'h00);
    ss_high();
    check("nop_done", nd - bd, 1);
    check("nop_err", ne - be, 0);
    check("nop_count", frame_count, 3);

    // last byte coincides with synchronized deselect
    ss_low();
    mark();
    send(8'h01); send(8'h33);
    @(negedge clk);
    spi_ss = 1'b1;
    repeat (2) @(negedge clk);
    byte_in    = 8'h44;
    byte_valid = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
    check("coin_wr_done", {reg_wr_en, frame_done, cmd_error}, 3'b110);
    check("coin_wdata", {reg_addr, reg_wr_data}, {7'h33, 8'h44});
    repeat (4) @(negedge clk);
    check("coin_count", frame_count, 4);
    check("coin_nwr", nw - bw, 1);

    // reset mid-burst
    ss_low();
    mark();
    send(8'h02); send(8'h40); send(8'h55);
    check("mid_wr", {reg_wr_en, reg_addr, reg_wr_data}, {1'b1, 7'h40, 8'h55});
    send(8'h66);
    rst_n = 1'b0;
    #1;
    check("mid_rst_outs", {reg_wr_en, reg_addr, reg_wr_data, busy, frame_done, cmd_error},
          0);
    check("mid_rst_count", frame_count, 0);
    spi_ss = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mark();
    repeat (6) @(negedge clk);
    check("post_rst_pulses", (nd - bd) + (ne - be), 0);
    check("post_rst_busy", busy, 0);

    // next frame parses normally; upper address bit ignored
    ss_low();
    mark();
    send(8'h01); send(8'hC5); send(8'h9A);
    ss_high();
    check("rec_nwr", nw - bw, 1);
    check("rec_w0", {wa[bw], wd[bw]}, {7'h45, 8'h9A});
    check("rec_done", nd - bd, 1);
    check("rec_count", frame_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/spi_cmd_controller.md
# spi_cmd_controller

Command sequencer between the SPI slave byte receiver and the design's configuration registers. Consumes the received byte stream one byte per `byte_valid` pulse and parses framed commands (opcode, address, data). Each frame is delimited by the SPI slave-select line. Produces single-cycle register write strobes with auto-incrementing addresses for bursts, and flags malformed frames.

## Interface
- `ADDR_W`, default 7: register address width; the address byte's low `ADDR_W` bits are used and the upper bits are ignored.
- `clk`  in  1: system clock, the same clock as the SPI slave.
- `rst_n`  in  1: asynchronous, active-low reset.
- `spi_ss`  in  1: raw SPI slave select, active low, asynchronous to `clk`.
- `byte_in`  in  8: received byte, valid while `byte_valid` is high.
- `byte_valid`  in  1: single-cycle pulse, one per received byte.
- `reg_wr_en`  out  1: single-cycle register write strobe.
- `reg_addr`  out  ADDR_W: write address, valid with `reg_wr_en`.
- `reg_wr_data`  out  8: write data, valid with `reg_wr_en`.
- `busy`  out  1: high while a frame is being parsed (state not IDLE).
- `frame_done`  out  1: single-cycle pulse when a well-formed frame ends.
- `cmd_error`  out  1: single-cycle pulse when a malformed frame ends.
- `frame_count`  out  8: count of well-formed frames; wraps from 255 to 0.

## Operation
- `spi_ss` passes through a 2-FF synchronizer, giving `ss_s`. `frame_end` is `ss_s` high while the state is not IDLE.
- Opcodes:
  - 0x00 NOP: no data; the frame ends legally after the opcode.
  - 0x01 WRITE_SINGLE: address byte, then exactly 1 data byte.
  - 0x02 WRITE_BURST: address byte, then 1 or more data bytes.
  - Any other value: illegal.
- States: IDLE, ADDR, DATA, DONE, DISCARD. Transitions on `byte_valid`:
  - IDLE: opcode 0x00 goes to DONE; 0x01 or 0x02 latches the opcode and goes to ADDR; an illegal opcode goes to DISCARD with the internal `err` flag set.
  - ADDR: latch `addr <= byte_in[ADDR_W-1:0]`, clear `wrote`, go to DATA.
  - DATA: issue a write of (`addr`, `byte_in`) and set `wrote`.
    - WRITE_SINGLE then goes to DONE.
    - WRITE_BURST stays in DATA with `addr <= addr + 1`, wrapping modulo 2^ADDR_W with no error.
  - DONE: any byte sets `err` and goes to DISCARD; no write is issued.
  - DISCARD: all bytes are ignored.
- A frame starts in IDLE when `ss_s` is low and the first `byte_valid` arrives. `byte_valid` while `ss_s` is high in IDLE is ignored.
- On `frame_end`, the state goes to IDLE and the frame is classified:
  - Well-formed: state DONE with `err` clear, or state DATA with `wrote` set. Pulse `frame_done` and increment `frame_count`.
  - Malformed: state ADDR, state DATA with `wrote` clear, or `err` set. Pulse `cmd_error`.
  - `err` and `wrote` are cleared on entry to IDLE.
- Writes are never retracted. A burst that later errors keeps the writes it already issued.

## Timing
- Reset values: `reg_wr_en`, `reg_addr`, `reg_wr_data`, `busy`, `frame_done`, `cmd_error` and `frame_count` are all 0; state is IDLE; the synchronizer flops are 1 (deselected).
- Write latency: `reg_wr_en`, `reg_addr` and `reg_wr_data` are registered and valid the cycle after `byte_valid`. `reg_addr`/`reg_wr_data` hold their last value otherwise.
- `busy` rises the cycle after the first `byte_valid` and falls the cycle after `frame_end` is processed.
- `frame_done` and `cmd_error` are registered, 1 cycle after the `frame_end` evaluation. They are mutually exclusive.
- SS deassertion is seen 2 cycles late through the synchronizer. If `byte_valid` and `frame_end` coincide:
  - The byte is processed first, including any write.
  - Classification uses the post-byte state.
  - The state then goes to IDLE in that same cycle.
- Back-to-back `byte_valid` on consecutive cycles is supported with no stalls.
- Reset mid-frame returns to IDLE immediately. Partial frames produce no pulse after reset.

## Test plan
- SINGLE write: SS low; bytes 0x01, 0x05, 0xA5; SS high -> exactly one `reg_wr_en` with addr 0x05 and data 0xA5; one `frame_done`; `frame_count`=1.
- BURST wrap (ADDR_W=7): bytes 0x02, 0x7E, 0x11, 0x22, 0x33 -> writes (0x7E,0x11), (0x7F,0x22), (0x00,0x33); then `frame_done`.
- Illegal opcode 0x55 followed by 3 bytes -> no writes; one `cmd_error` on SS high; `frame_count` unchanged.
- SINGLE with an extra byte: 0x01, 0x10, 0x01, 0x02 -> one write (0x10,0x01) only; `cmd_error`; not counted.
- Truncated frame: 0x02, 0x20, then SS high -> no write, `cmd_error`. Next, a NOP frame (0x00 alone) -> `frame_done`.
- Last byte's `byte_valid` coincides with synchronized SS high -> write still issued and `frame_done` asserted. Separately, assert `rst_n` low mid-burst -> all outputs 0, no pulse; the next frame parses normally.
